// File: rtl/pa2se_pingpong_pkg.sv
// Shared constants, state encodings and the sample-to-address mapping
// used by the 4-lane parallel to serial ping-pong converter.
package pa2se_pingpong_pkg;

    localparam int NB_DEFAULT = 16;  // default width of one real or imag sample
    localparam int NPT        = 32;  // points per frame
    localparam int VPF        = 8;   // vectors per frame (NPT / LANES)
    localparam int LANES      = 4;   // lanes per input vector

    // Life cycle of one frame bank.
    typedef enum logic [1:0] {
        BANK_EMPTY   = 2'd0,
        BANK_FILLING = 2'd1,
        BANK_FULL    = 2'd2,
        BANK_READING = 2'd3
    } bank_state_t;

    typedef enum logic {
        WR_IDLE  = 1'b0,
        WR_WRITE = 1'b1
    } wr_state_t;

    typedef enum logic {
        RD_IDLE   = 1'b0,
        RD_STREAM = 1'b1
    } rd_state_t;

    // Bank address is {vec[2:0], lane[1:0]}.
    // Vector-major: sample k is lane k%4 of vec k/4, so the address is k.
    // Lane-major:   sample k is lane k/8 of vec k%8.
    function automatic logic [4:0] sample_addr(input logic [4:0] k, input logic lane_major);
        if (lane_major) begin
            return {k[2:0], k[4:3]};
        end
        return k;
    endfunction

endpackage

// File: rtl/pa2se_bank.sv
// One 32 x 2nb frame bank: a 4-lane vector write port and a registered
// single-sample read port. Storage is split per lane so each lane is a
// simple 8-deep dual-port array.
module pa2se_bank
    import pa2se_pingpong_pkg::*;
#(
    parameter int nb = NB_DEFAULT
) (
    input  logic              i_clk,
    input  logic              i_srst,
    input  logic              i_wr_en,
    input  logic [2:0]        i_wr_vec,
    input  logic [4*nb-1:0]   i_wr_re,
    input  logic [4*nb-1:0]   i_wr_im,
    input  logic              i_rd_en,
    input  logic [4:0]        i_rd_addr,
    output logic [nb-1:0]     o_rd_re,
    output logic [nb-1:0]     o_rd_im
);

    logic [LANES-1:0][2*nb-1:0] w_lane_q;
    logic [1:0]                 r_lane_sel;

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic [2*nb-1:0] mem [VPF];
            logic [2*nb-1:0] r_q;

            // Lane write: every lane of a vector lands at the same vec address.
            always_ff @(posedge i_clk) begin
                if (i_wr_en) begin
                    mem[i_wr_vec] <= {i_wr_im[gi*nb +: nb], i_wr_re[gi*nb +: nb]};
                end
            end

            // Registered lane read; cleared on reset so the serial output reads zero.
            always_ff @(posedge i_clk) begin
                if (i_srst) begin
                    r_q <= '0;
                end else if (i_rd_en) begin
                    r_q <= mem[i_rd_addr[4:2]];
                end
            end

            assign w_lane_q[gi] = r_q;
        end
    endgenerate

    // Remember which lane the read address asked for, aligned with the lane registers.
    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            r_lane_sel <= 2'd0;
        end else if (i_rd_en) begin
            r_lane_sel <= i_rd_addr[1:0];
        end
    end

    assign o_rd_re = w_lane_q[r_lane_sel][nb-1:0];
    assign o_rd_im = w_lane_q[r_lane_sel][2*nb-1:nb];

endmodule

// File: rtl/pa2se_pingpong.sv
// 4-lane parallel to serial converter with a ping-pong pair of frame
// banks: one frame is written as 8 vectors while the previous one is
// streamed out one sample per cycle. Writer FSM, reader FSM and the
// per-bank state bookkeeping live here.
module pa2se_pingpong
    import pa2se_pingpong_pkg::*;
#(
    parameter int nb    = NB_DEFAULT,
    parameter int ORDER = 0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              START,
    input  logic              ED,
    input  logic [4*nb-1:0]   DR,
    input  logic [4*nb-1:0]   DI,
    output logic [nb-1:0]     OR,
    output logic [nb-1:0]     OI,
    output logic              OV,
    output logic              RDY,
    output logic              OVF
);

    // Registered state
    bank_state_t r_bstate [2];
    wr_state_t   r_wr_state;
    rd_state_t   r_rd_state;
    logic        r_wbank;
    logic [2:0]  r_wcnt;
    logic        r_rbank;
    logic [4:0]  r_rcnt;
    logic        r_older;   // bank that became FULL first while both are FULL
    logic        r_obank;   // bank currently feeding OR/OI
    logic        r_ov;
    logic        r_rdy;
    logic        r_ovf;

    // Next-state and datapath controls
    bank_state_t w_bstate_next [2];
    wr_state_t   w_wr_state_next;
    rd_state_t   w_rd_state_next;
    logic        w_wbank_next;
    logic [2:0]  w_wcnt_next;
    logic        w_rbank_next;
    logic [4:0]  w_rcnt_next;
    logic        w_older_next;
    logic        w_ovf_next;
    logic        w_start;
    logic        w_any_empty;
    logic        w_empty_bank;
    logic        w_full0;
    logic        w_full1;
    logic        w_rsel;
    logic        w_wr_en;
    logic [2:0]  w_wr_vec;
    logic        w_rd_en;
    logic [4:0]  w_rd_k;
    logic [4:0]  w_rd_addr;
    logic [1:0][nb-1:0] w_bank_re;
    logic [1:0][nb-1:0] w_bank_im;

    assign w_start      = START & ED;
    assign w_any_empty  = (r_bstate[0] == BANK_EMPTY) || (r_bstate[1] == BANK_EMPTY);
    assign w_empty_bank = (r_bstate[0] == BANK_EMPTY) ? 1'b0 : 1'b1;
    assign w_full0      = (r_bstate[0] == BANK_FULL);
    assign w_full1      = (r_bstate[1] == BANK_FULL);
    assign w_rd_addr    = sample_addr(w_rd_k, ORDER != 0);

    // Writer and reader next-state logic; the writer only moves banks out of
    // EMPTY/FILLING and the reader only out of FULL/READING, so they never
    // update the same bank in one cycle.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            w_bstate_next[i] = r_bstate[i];
        end
        w_wr_state_next = r_wr_state;
        w_rd_state_next = r_rd_state;
        w_wbank_next    = r_wbank;
        w_wcnt_next     = r_wcnt;
        w_rbank_next    = r_rbank;
        w_rcnt_next     = r_rcnt;
        w_older_next    = r_older;
        w_ovf_next      = r_ovf;
        w_rsel          = 1'b0;
        w_wr_en         = 1'b0;
        w_wr_vec        = 3'd0;
        w_rd_en         = 1'b0;
        w_rd_k          = 5'd0;

        // Writer: claim the lowest EMPTY bank on START, fill 8 vectors.
        // A bank freed by the reader this very cycle is still READING here,
        // so a START that needs it is dropped.
        case (r_wr_state)
            WR_IDLE: begin
                if (w_start) begin
                    if (w_any_empty) begin
                        w_wbank_next                 = w_empty_bank;
                        w_bstate_next[w_empty_bank]  = BANK_FILLING;
                        w_wr_en                      = 1'b1;
                        w_wr_vec                     = 3'd0;
                        w_wcnt_next                  = 3'd1;
                        w_wr_state_next              = WR_WRITE;
                    end else begin
                        w_ovf_next = 1'b1;
                    end
                end
            end
            WR_WRITE: begin
                if (w_start) begin
                    // Abort the partial frame and restart in the same bank.
                    w_wr_en     = 1'b1;
                    w_wr_vec    = 3'd0;
                    w_wcnt_next = 3'd1;
                end else if (ED) begin
                    w_wr_en  = 1'b1;
                    w_wr_vec = r_wcnt;
                    if (r_wcnt == 3'(VPF - 1)) begin
                        w_bstate_next[r_wbank] = BANK_FULL;
                        w_wr_state_next        = WR_IDLE;
                        w_wcnt_next            = 3'd0;
                        if (r_bstate[~r_wbank] != BANK_FULL) begin
                            w_older_next = r_wbank;
                        end
                    end else begin
                        w_wcnt_next = r_wcnt + 3'd1;
                    end
                end
            end
            default: w_wr_state_next = WR_IDLE;
        endcase

        // Reader: pick a FULL bank (oldest first), then stream 32 samples.
        case (r_rd_state)
            RD_IDLE: begin
                if (w_full0 || w_full1) begin
                    w_rsel                = (w_full0 && w_full1) ? r_older : (w_full0 ? 1'b0 : 1'b1);
                    w_bstate_next[w_rsel] = BANK_READING;
                    w_rd_en               = 1'b1;
                    w_rd_k                = 5'd0;
                    w_rbank_next          = w_rsel;
                    w_rcnt_next           = 5'd1;
                    w_rd_state_next       = RD_STREAM;
                end
            end
            RD_STREAM: begin
                w_rd_en = 1'b1;
                w_rd_k  = r_rcnt;
                if (r_rcnt == 5'(NPT - 1)) begin
                    w_bstate_next[r_rbank] = BANK_EMPTY;
                    w_rcnt_next            = 5'd0;
                    w_rd_state_next        = RD_IDLE;
                end else begin
                    w_rcnt_next = r_rcnt + 5'd1;
                end
            end
            default: w_rd_state_next = RD_IDLE;
        endcase
    end

    // State registers, output flags and sticky overflow.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < 2; i++) begin
                r_bstate[i] <= BANK_EMPTY;
            end
            r_wr_state <= WR_IDLE;
            r_rd_state <= RD_IDLE;
            r_wbank    <= 1'b0;
            r_wcnt     <= 3'd0;
            r_rbank    <= 1'b0;
            r_rcnt     <= 5'd0;
            r_older    <= 1'b0;
            r_obank    <= 1'b0;
            r_ov       <= 1'b0;
            r_rdy      <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                r_bstate[i] <= w_bstate_next[i];
            end
            r_wr_state <= w_wr_state_next;
            r_rd_state <= w_rd_state_next;
            r_wbank    <= w_wbank_next;
            r_wcnt     <= w_wcnt_next;
            r_rbank    <= w_rbank_next;
            r_rcnt     <= w_rcnt_next;
            r_older    <= w_older_next;
            r_ovf      <= w_ovf_next;
            r_ov       <= w_rd_en;
            r_rdy      <= w_rd_en && (w_rd_k == 5'd0);
            if (w_rd_en) begin
                r_obank <= w_rbank_next;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_bank
            pa2se_bank #(
                .nb (nb)
            ) u_bank (
                .i_clk     (CLK),
                .i_srst    (RST),
                .i_wr_en   (w_wr_en && (w_wbank_next == 1'(gi))),
                .i_wr_vec  (w_wr_vec),
                .i_wr_re   (DR),
                .i_wr_im   (DI),
                .i_rd_en   (w_rd_en && (w_rbank_next == 1'(gi))),
                .i_rd_addr (w_rd_addr),
                .o_rd_re   (w_bank_re[gi]),
                .o_rd_im   (w_bank_im[gi])
            );
        end
    endgenerate

    // Banks hold their read registers when idle, so OR/OI hold too.
    assign OR  = r_obank ? w_bank_re[1] : w_bank_re[0];
    assign OI  = r_obank ? w_bank_im[1] : w_bank_im[0];
    assign OV  = r_ov;
    assign RDY = r_rdy;
    assign OVF = r_ovf;

endmodule

// File: tb/tb_pa2se_pingpong.sv
// Bench for the parallel to serial ping-pong converter: one DUT per output
// ordering, both driven by the same stimulus and checked every cycle
// against a frame-queue model, plus literal checks of the directed cases.
module tb_pa2se_pingpong;

    localparam int NB = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic            start;
    logic            ed;
    logic [4*NB-1:0] dr;
    logic [4*NB-1:0] di;
    logic [NB-1:0]   or0, oi0, or1, oi1;
    logic            ov0, rdy0, ovf0, ov1, rdy1, ovf1;

    pa2se_pingpong #(.nb(NB), .ORDER(0)) u_dut0 (
        .CLK(clk), .RST(rst), .START(start), .ED(ed), .DR(dr), .DI(di),
        .OR(or0), .OI(oi0), .OV(ov0), .RDY(rdy0), .OVF(ovf0)
    );

    pa2se_pingpong #(.nb(NB), .ORDER(1)) u_dut1 (
        .CLK(clk), .RST(rst), .START(start), .ED(ed), .DR(dr), .DI(di),
        .OR(or1), .OI(oi1), .OV(ov1), .RDY(rdy1), .OVF(ovf1)
    );

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // A frame being filled, a FIFO of finished frames (vector-major, 32
    // samples each, head = frame on the output), and an occupancy rule:
    // at most two frames may be filling, waiting or streaming at once.
    logic [NB-1:0] m_fre [32];
    logic [NB-1:0] m_fim [32];
    logic [NB-1:0] q_re [$];
    logic [NB-1:0] q_im [$];
    bit            m_filling, m_reading, m_valid;
    int            m_fill, m_wait, m_ridx, cyc_n;
    logic          e_ov, e_rdy, e_ovf;
    logic [NB-1:0] e_or0, e_oi0, e_or1, e_oi1;

    initial begin
        m_valid = 0; cyc_n = 0;
        forever begin
            @(posedge clk);
            cyc_n++;
            if (rst) begin
                m_filling = 0; m_reading = 0; m_fill = 0; m_wait = 0; m_ridx = 0;
                q_re.delete(); q_im.delete();
                e_ov = 0; e_rdy = 0; e_ovf = 0;
                e_or0 = '0; e_oi0 = '0; e_or1 = '0; e_oi1 = '0;
            end else begin
                int occ, k, kt;
                occ = int'(m_filling) + m_wait + int'(m_reading);
                e_ov = 0; e_rdy = 0;
                if (m_reading || m_wait > 0) begin
                    if (!m_reading) begin
                        m_reading = 1; m_wait--; m_ridx = 0; e_rdy = 1;
                    end
                    k  = m_ridx;
                    kt = (k % 8) * 4 + k / 8;
                    e_ov = 1;
                    e_or0 = q_re[k];  e_oi0 = q_im[k];
                    e_or1 = q_re[kt]; e_oi1 = q_im[kt];
                    m_ridx++;
                    if (m_ridx == 32) begin
                        m_reading = 0;
                        repeat (32) begin
                            void'(q_re.pop_front());
                            void'(q_im.pop_front());
                        end
                    end
                end
                if (start && ed) begin
                    if (m_filling || occ < 2) begin
                        m_filling = 1;
                        for (int l = 0; l < 4; l++) begin
                            m_fre[l] = dr[l*NB +: NB];
                            m_fim[l] = di[l*NB +: NB];
                        end
                        m_fill = 1;
                    end else begin
                        e_ovf = 1;
                    end
                end else if (ed && m_filling) begin
                    for (int l = 0; l < 4; l++) begin
                        m_fre[m_fill*4+l] = dr[l*NB +: NB];
                        m_fim[m_fill*4+l] = di[l*NB +: NB];
                    end
                    m_fill++;
                    if (m_fill == 8) begin
                        m_filling = 0;
                        m_wait++;
                        for (int i = 0; i < 32; i++) begin
                            q_re.push_back(m_fre[i]);
                            q_im.push_back(m_fim[i]);
                        end
                    end
                end
            end
            m_valid = 1;
        end
    end

    // ---------------- compare and capture ----------------
    logic [NB-1:0] cap0 [$];
    logic [NB-1:0] cap1 [$];
    int run_len, max_run, n_rdy, rdy_cyc;

    initial begin
        run_len = 0; max_run = 0; n_rdy = 0; rdy_cyc = 0;
        forever begin
            @(negedge clk);
            if (m_valid) begin
                chk("ov0",  32'(ov0),  32'(e_ov));
                chk("rdy0", 32'(rdy0), 32'(e_rdy));
                chk("ovf0", 32'(ovf0), 32'(e_ovf));
                chk("or0",  32'(or0),  32'(e_or0));
                chk("oi0",  32'(oi0),  32'(e_oi0));
                chk("ov1",  32'(ov1),  32'(e_ov));
                chk("rdy1", 32'(rdy1), 32'(e_rdy));
                chk("ovf1", 32'(ovf1), 32'(e_ovf));
                chk("or1",  32'(or1),  32'(e_or1));
                chk("oi1",  32'(oi1),  32'(e_oi1));
                if (ov0) begin
                    cap0.push_back(or0);
                    cap1.push_back(or1);
                    run_len++;
                    if (run_len > max_run) max_run = run_len;
                end else begin
                    run_len = 0;
                end
                if (rdy0) begin
                    n_rdy++;
                    rdy_cyc = cyc_n;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input bit s, input bit e, input bit directed, input int v);
        @(negedge clk); #1;
        start = s; ed = e;
        for (int l = 0; l < 4; l++) begin
            dr[l*NB +: NB] = directed ? NB'(v*4 + l) : NB'($urandom);
            di[l*NB +: NB] = directed ? NB'(v*4 + l) : NB'($urandom);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(0, 0, 0, 0);
    endtask

    task automatic send_frame(input bit directed);
        for (int v = 0; v < 8; v++) cyc(v == 0, 1, directed, v);
    endtask

    task automatic clear_caps();
        cap0.delete(); cap1.delete();
        max_run = 0; n_rdy = 0;
    endtask

    task automatic do_reset(input int n);
        @(negedge clk); #1;
        rst = 1; start = 0; ed = 0;
        repeat (n) @(negedge clk);
        #1 rst = 0;
    endtask

    initial begin
        int wr_cyc;
        rst = 1; start = 0; ed = 0; dr = '0; di = '0;
        repeat (3) @(negedge clk);
        chk("reset_ov", 32'(ov0), 32'd0);
        chk("reset_or", 32'(or0), 32'd0);
        chk("reset_ovf", 32'(ovf1), 32'd0);
        #1 rst = 0;

        // Single directed frame: vector-major 0..31, lane-major transpose.
        clear_caps();
        send_frame(1);
        wr_cyc = cyc_n + 1;
        idle(40);
        chk("t1_count", 32'(cap0.size()), 32'd32);
        chk("t1_run", 32'(max_run), 32'd32);
        chk("t1_latency", 32'(rdy_cyc - wr_cyc), 32'd1);
        if (cap0.size() == 32) begin
            chk("t1_o0_s0", 32'(cap0[0]), 32'd0);
            chk("t1_o0_s17", 32'(cap0[17]), 32'd17);
            chk("t1_o0_s31", 32'(cap0[31]), 32'd31);
            chk("t1_o1_s1", 32'(cap1[1]), 32'd4);
            chk("t1_o1_s8", 32'(cap1[8]), 32'd1);
            chk("t1_o1_s30", 32'(cap1[30]), 32'd27);
            chk("t1_o1_s31", 32'(cap1[31]), 32'd31);
        end

        // Two frames back-to-back: 64 contiguous samples, two RDY pulses.
        clear_caps();
        send_frame(0); send_frame(0);
        idle(80);
        chk("t2_count", 32'(cap0.size()), 32'd64);
        chk("t2_run", 32'(max_run), 32'd64);
        chk("t2_rdy", 32'(n_rdy), 32'd2);
        chk("t2_ovf", 32'(ovf0), 32'd0);

        // Three frames back-to-back: third dropped, OVF sticky.
        clear_caps();
        send_frame(0); send_frame(0); send_frame(0);
        idle(100);
        chk("t3_count", 32'(cap0.size()), 32'd64);
        chk("t3_ovf", 32'(ovf0), 32'd1);
        chk("t3_rdy", 32'(n_rdy), 32'd2);
        do_reset(2);

        // START re-asserted at vec 5: only the fresh frame comes out.
        clear_caps();
        for (int v = 0; v < 5; v++) cyc(v == 0, 1, 0, v);
        send_frame(1);
        idle(40);
        chk("t4_count", 32'(cap0.size()), 32'd32);
        chk("t4_ovf", 32'(ovf0), 32'd0);
        if (cap0.size() == 32) chk("t4_s5", 32'(cap0[5]), 32'd5);

        // Reset at output sample 10, then a clean new frame.
        clear_caps();
        send_frame(1);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk); #1;
            start = 0; ed = 0;
            if (cap0.size() >= 11) break;
        end
        chk("t5_reached_s10", 32'(cap0.size()), 32'd11);
        rst = 1;
        @(negedge clk);
        chk("t5_ov_after_rst", 32'(ov0), 32'd0);
        chk("t5_or_after_rst", 32'(or0), 32'd0);
        #1 rst = 0;
        clear_caps();
        idle(40);
        chk("t5_no_output", 32'(cap0.size()), 32'd0);
        send_frame(1);
        idle(40);
        chk("t5_new_count", 32'(cap0.size()), 32'd32);

        // Randomized traffic with occasional resets, checked by the model.
        for (int i = 0; i < 3000; i++) begin
            int r;
            bit e, s;
            r = $urandom_range(0, 99);
            e = (r < 85);
            s = e && ($urandom_range(0, 99) < 9);
            if ($urandom_range(0, 999) < 3) begin
                do_reset(1);
            end else begin
                cyc(s, e, 0, 0);
            end
        end
        idle(80);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
